// File: rtl/coreaxitoahbl_rdbuf_drain_ctrl.sv
// Read-side drain sequencer for the AXI-to-AHBL buffer RAM: issues burst reads,
// absorbs the two-cycle RAM read latency in a 4-entry skid FIFO and streams beats out.
//   state   | meaning
//   S_IDLE  | waiting for a descriptor; the first read is issued on the accept edge
//   S_READ  | issuing the remaining reads, throttled by FIFO space
//   S_DRAIN | all reads issued, waiting for the last beat handshake
module coreaxitoahbl_rdbuf_drain_ctrl #(
  parameter int AXI_DWIDTH = 64,
  parameter int AXI_LWIDTH = 4
) (
  input  logic                  rdCLK,
  input  logic                  RESETN,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [AXI_LWIDTH-1:0] desc_addr,
  input  logic [7:0]            desc_len,
  input  logic                  abort,
  output logic [AXI_LWIDTH-1:0] rdAddr,
  input  logic [AXI_DWIDTH-1:0] rdData,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AXI_DWIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  init_q;
  logic [AXI_LWIDTH-1:0] rdaddr_q, rdaddr_d;
  logic [7:0]            beats_left_q, beats_left_d;
  logic [1:0]            inflight_q, inflight_d;
  logic                  p1_vld_q, p1_vld_d, p1_last_q, p1_last_d;
  logic                  p2_vld_q, p2_vld_d, p2_last_q, p2_last_d;
  logic [AXI_DWIDTH-1:0] fifo_data_q [4];
  logic [3:0]            fifo_last_q;
  logic [1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]            count_q, count_d;
  logic                  done_q, done_d;

  logic accept, issue, issue_last, push, pop, flush, head_last, has_room;

  assign desc_ready = (state_q == S_IDLE) & init_q & ~abort;
  assign accept     = desc_valid & desc_ready;
  assign out_valid  = (count_q != 3'd0);
  assign pop        = out_valid & out_ready;
  assign head_last  = fifo_last_q[rd_ptr_q];
  // Space is reserved for every read still travelling through the RAM pipeline.
  assign has_room   = (4'(count_q) + 4'(inflight_q)) < 4'd4;

  assign rdAddr   = rdaddr_q;
  assign out_data = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_last = out_valid & head_last;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

  always_comb begin
    state_d      = state_q;
    rdaddr_d     = rdaddr_q;
    beats_left_d = beats_left_q;
    issue        = 1'b0;
    issue_last   = 1'b0;
    done_d       = 1'b0;
    flush        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          issue        = 1'b1;
          rdaddr_d     = desc_addr;
          beats_left_d = desc_len;
          issue_last   = (desc_len == 8'd0);
          state_d      = issue_last ? S_DRAIN : S_READ;
        end
      end
      S_READ: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (has_room) begin
          issue        = 1'b1;
          rdaddr_d     = rdaddr_q + AXI_LWIDTH'(1);
          beats_left_d = beats_left_q - 8'd1;
          issue_last   = (beats_left_q == 8'd1);
          if (issue_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (pop && head_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Two-stage tag pipeline mirrors rdAddr register -> RAM address register.
  always_comb begin
    push      = p2_vld_q & ~flush;
    p1_vld_d  = issue;
    p1_last_d = issue_last;
    p2_vld_d  = p1_vld_q & ~flush;
    p2_last_d = p1_last_q;
    if (flush) begin
      inflight_d = 2'd0;
      wr_ptr_d   = 2'd0;
      rd_ptr_d   = 2'd0;
      count_d    = 3'd0;
    end else begin
      inflight_d = inflight_q + 2'(issue) - 2'(push);
      wr_ptr_d   = wr_ptr_q + 2'(push);
      rd_ptr_d   = rd_ptr_q + 2'(pop);
      count_d    = count_q + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge rdCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= S_IDLE;
      init_q       <= 1'b0;
      rdaddr_q     <= '0;
      beats_left_q <= 8'd0;
      inflight_q   <= 2'd0;
      p1_vld_q     <= 1'b0;
      p1_last_q    <= 1'b0;
      p2_vld_q     <= 1'b0;
      p2_last_q    <= 1'b0;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      count_q      <= 3'd0;
      fifo_last_q  <= 4'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_q       <= 1'b1;
      rdaddr_q     <= rdaddr_d;
      beats_left_q <= beats_left_d;
      inflight_q   <= inflight_d;
      p1_vld_q     <= p1_vld_d;
      p1_last_q    <= p1_last_d;
      p2_vld_q     <= p2_vld_d;
      p2_last_q    <= p2_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      done_q       <= done_d;
      if (push) fifo_last_q[wr_ptr_q] <= p2_last_q;
    end
  end

  // Payload storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge rdCLK) begin
    if (push) fifo_data_q[wr_ptr_q] <= rdData;
  end

endmodule

// File: tb/tb_coreaxitoahbl_rdbuf_drain_ctrl.sv
// Bench for coreaxitoahbl_rdbuf_drain_ctrl: directed descriptor table, corner
// sequences (abort, back-to-back, abort in idle) and randomized bursts vs a queue model.
module tb_coreaxitoahbl_rdbuf_drain_ctrl;
  localparam int DW = 64;
  localparam int LW = 4;
  localparam int DEPTH = 16;

  logic          rdCLK = 1'b0;
  logic          RESETN = 1'b0;
  logic          desc_valid = 1'b0;
  logic          desc_ready;
  logic [LW-1:0] desc_addr = '0;
  logic [7:0]    desc_len = '0;
  logic          abort = 1'b0;
  logic [LW-1:0] rdAddr;
  logic [DW-1:0] rdData = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];

  coreaxitoahbl_rdbuf_drain_ctrl #(.AXI_DWIDTH(DW), .AXI_LWIDTH(LW)) dut (
    .rdCLK(rdCLK), .RESETN(RESETN),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr), .desc_len(desc_len),
    .abort(abort), .rdAddr(rdAddr), .rdData(rdData),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 rdCLK = ~rdCLK;

  // Buffer RAM with a registered read address.
  always @(posedge rdCLK) rdData <= mem[rdAddr];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge rdCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } beat_t;
  beat_t exp_q[$];

  bit            mon_en = 0;
  bit            exp_done_nxt = 0, exp_idle_nxt = 0, stall_prev = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  bit            trk_on = 0, pend_on = 0, lat_pend = 0;
  logic [LW-1:0] trk_base = '0, pend_base = '0;
  logic [LW-1:0] addr_log[$];
  int            popped = 0, c0 = 0, lat_meas = 0;
  int            beats_seen = 0, total_beats = 0, done_cnt = 0;
  logic [DW-1:0] first_d = '0, last_d = '0;

  // Reference model: each accepted descriptor expands into its beat list.
  always @(negedge rdCLK) begin
    if (mon_en) begin
      beat_t b;
      logic [LW-1:0] diff;
      int issued;
      if (pend_on) begin
        trk_on = 1; trk_base = pend_base; popped = 0; pend_on = 0;
        addr_log.delete();
        addr_log.push_back(rdAddr);
      end else if (trk_on && rdAddr != addr_log[$]) begin
        addr_log.push_back(rdAddr);
      end
      chk("done_pulse", done, exp_done_nxt);
      chk("desc_ready_rule", desc_ready, !busy && !abort);
      if (exp_idle_nxt) begin
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
      end
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (trk_on) begin
        diff = rdAddr - trk_base;
        issued = int'(diff) + 1;
        chk("outstanding_le4", (issued - popped) <= 4, 1);
      end
      if (lat_pend && out_valid) begin
        lat_meas = cyc - c0;
        lat_pend = 0;
      end
      exp_done_nxt = 0;
      exp_idle_nxt = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_beat", out_valid, 0);
        else begin
          b = exp_q.pop_front();
          chk("beat_data", out_data, b.d);
          chk("beat_last", out_last, b.last);
          if (beats_seen == 0) first_d = out_data;
          last_d = out_data;
          beats_seen++; total_beats++; popped++;
          if (b.last) begin exp_done_nxt = !abort; trk_on = 0; end
        end
      end
      if (abort && busy) begin
        exp_q.delete();
        exp_idle_nxt = 1; exp_done_nxt = 0;
        trk_on = 0; pend_on = 0; lat_pend = 0;
      end
      if (desc_valid && desc_ready) begin
        for (int i = 0; i <= int'(desc_len); i++) begin
          b.d = mem[(int'(desc_addr) + i) % DEPTH];
          b.last = (i == int'(desc_len));
          exp_q.push_back(b);
        end
        pend_on = 1; pend_base = desc_addr; c0 = cyc; lat_pend = 1; beats_seen = 0;
      end
      stall_prev = out_valid && !out_ready && !(abort && busy);
      prev_data = out_data;
      prev_last = out_last;
      if (done) done_cnt++;
    end
  end

  function automatic logic ready_of(input int m, input int k);
    case (m)
      0:       return 1'b1;
      1:       return (k % 3) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // Presents one descriptor and runs until done, or until the planned abort.
  task automatic run_desc(input logic [LW-1:0] a, input logic [7:0] l, input int rmode, input int abort_at);
    bit got, ab;
    @(posedge rdCLK); #1;
    desc_valid = 1; desc_addr = a; desc_len = l; out_ready = ready_of(rmode, 0);
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge rdCLK);
      if (desc_ready) begin got = 1; break; end
    end
    chk("desc_accept", got, 1);
    @(posedge rdCLK); #1;
    desc_valid = 0;
    got = 0; ab = 0;
    for (int k = 0; k < 600; k++) begin
      out_ready = ready_of(rmode, k);
      if (abort_at >= 0 && k == abort_at && busy) begin abort = 1; ab = 1; end
      @(negedge rdCLK);
      if (done || ab) begin got = 1; break; end
      @(posedge rdCLK); #1;
    end
    chk("burst_end", got, 1);
    @(posedge rdCLK); #1;
    abort = 0; out_ready = 0;
  endtask

  typedef struct {
    logic [LW-1:0] a;
    logic [7:0]    l;
    int            rmode;
    int            beats;
    logic [DW-1:0] first;
    logic [DW-1:0] last;
  } vec_t;
  vec_t vt[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int cnt, d0, tb1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 64'h100 + 64'(i);
    vt[0] = '{4'd2,  8'd3,  0, 4,  64'h102, 64'h105};
    vt[1] = '{4'd14, 8'd3,  0, 4,  64'h10e, 64'h101};
    vt[2] = '{4'd5,  8'd7,  1, 8,  64'h105, 64'h10c};
    vt[3] = '{4'd0,  8'd0,  0, 1,  64'h100, 64'h100};
    vt[4] = '{4'd15, 8'd15, 2, 16, 64'h10f, 64'h10e};

    // Reset values, then desc_ready on the first clock after release.
    repeat (3) @(posedge rdCLK);
    @(negedge rdCLK);
    chk("rst_desc_ready", desc_ready, 0);
    chk("rst_rdAddr", rdAddr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge rdCLK); #1;
    RESETN = 1;
    @(negedge rdCLK);
    chk("ready_before_clk", desc_ready, 0);
    @(negedge rdCLK);
    chk("ready_after_clk", desc_ready, 1);
    @(posedge rdCLK); #1;
    mon_en = 1;

    for (int v = 0; v < 5; v++) begin
      run_desc(vt[v].a, vt[v].l, vt[v].rmode, -1);
      chk($sformatf("vec%0d_beats", v), beats_seen, vt[v].beats);
      chk($sformatf("vec%0d_first", v), first_d, vt[v].first);
      chk($sformatf("vec%0d_last", v), last_d, vt[v].last);
      chk($sformatf("vec%0d_latency", v), lat_meas, 3);
      if (v == 1) begin
        chk("wrap_addr_count", addr_log.size(), 4);
        for (int i = 0; i < addr_log.size() && i < 4; i++)
          chk($sformatf("wrap_addr%0d", i), addr_log[i], (14 + i) % DEPTH);
      end
    end

    // Abort after five accepted beats of a 16-beat burst.
    @(posedge rdCLK); #1;
    d0 = done_cnt;
    desc_valid = 1; desc_addr = 0; desc_len = 15; out_ready = 1;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge rdCLK);
      if (desc_ready) begin got = 1; break; end
    end
    chk("abort_desc_accept", got, 1);
    @(posedge rdCLK); #1;
    desc_valid = 0;
    cnt = 0; got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge rdCLK);
      if (out_valid && out_ready) cnt++;
      if (cnt == 5) begin got = 1; break; end
    end
    chk("abort_reach5", got, 1);
    @(posedge rdCLK); #1;
    abort = 1; out_ready = 0;
    @(posedge rdCLK); #1;
    abort = 0;
    @(negedge rdCLK);
    chk("abort_valid_next", out_valid, 0);
    chk("abort_idle", busy, 0);
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge rdCLK);
      chk("abort_stale_discard", out_valid, 0);
    end
    @(posedge rdCLK); #1;
    chk("abort_beats", beats_seen, 5);
    chk("abort_no_done", done_cnt, d0);
    run_desc(0, 0, 0, -1);
    chk("post_abort_beats", beats_seen, 1);
    chk("post_abort_data", first_d, 64'h100);

    // Abort together with desc_valid in IDLE: descriptor refused.
    @(posedge rdCLK); #1;
    desc_valid = 1; desc_addr = 3; desc_len = 2; abort = 1;
    @(negedge rdCLK);
    chk("idle_abort_ready", desc_ready, 0);
    @(posedge rdCLK); #1;
    desc_valid = 0; abort = 0;
    @(negedge rdCLK);
    chk("idle_abort_busy", busy, 0);

    // Back-to-back descriptors with desc_valid held.
    @(posedge rdCLK); #1;
    desc_valid = 1; desc_addr = 3; desc_len = 0; out_ready = 1;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge rdCLK);
      if (desc_ready) begin got = 1; break; end
    end
    chk("b2b_first_accept", got, 1);
    @(posedge rdCLK); #1;
    tb1 = total_beats; d0 = done_cnt;
    desc_addr = 8; desc_len = 1;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge rdCLK);
      if (desc_ready) begin got = 1; break; end
    end
    chk("b2b_second_accept", got, 1);
    chk("b2b_accept_in_done", done, 1);
    @(posedge rdCLK); #1;
    desc_valid = 0;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge rdCLK);
      if (done) begin got = 1; break; end
    end
    chk("b2b_second_done", got, 1);
    @(posedge rdCLK); #1;
    chk("b2b_total_beats", total_beats - tb1, 3);
    chk("b2b_done_pulses", done_cnt - d0, 2);
    out_ready = 0;

    // Randomized bursts, random backpressure, occasional abort.
    for (int n = 0; n < 40; n++) begin
      int ab_at;
      for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
      ab_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_desc(LW'($urandom_range(0, DEPTH - 1)), 8'($urandom_range(0, 15)),
               int'($urandom_range(0, 2)), ab_at);
      repeat (4) @(posedge rdCLK);
      #1;
      chk("rand_queue_drained", exp_q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
